regbank_2r1w: RTL and testbench
===============================

# regbank_2r1w

Thirty-two-entry by 32-bit register bank for the 32-bit processor datapath. It has one write port and two independent registered read ports, S and T, each with a read-enable/valid handshake. Same-cycle write-to-read forwarding is built in. The bank sits between the decode stage, which presents the rs/rt addresses, and the ALU operand latches. Register 0 is hardwired to zero.

## Interface
- DATA_W, 32, width of each entry and of the data ports
- ADDR_W, 5, address width; depth is 2**ADDR_W (32 entries)
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-low reset; the bank is held in reset while low
- we  in  1  write enable, sampled on the rising clk edge
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- re_s  in  1  port S read request
- raddr_s  in  ADDR_W  port S address
- rdata_s  out  DATA_W  port S registered read data
- rvalid_s  out  1  port S data valid, a one-cycle pulse
- re_t  in  1  port T read request
- raddr_t  in  ADDR_W  port T address
- rdata_t  out  DATA_W  port T registered read data
- rvalid_t  out  1  port T data valid, a one-cycle pulse

## Operation
- **Reset:** while reset is low, all 32 entries, rdata_s, rdata_t, rvalid_s and rvalid_t are 0, regardless of clk.
- **Write:** on a rising edge with we=1 and waddr!=0, entry[waddr] takes wdata. A write with waddr=0 is discarded, so entry 0 always reads 0.
- **Read (each port independently, shown for port S):** on a rising edge with re_s=1, rdata_s is loaded with:
  - 0 if raddr_s=0;
  - otherwise wdata if we=1 and waddr=raddr_s (forwarding);
  - otherwise entry[raddr_s].
- **Valid:** rvalid_s is the registered value of re_s. It goes high on the edge that loads the data and returns low on the next edge unless re_s is still high.
- **Idle port:** with re_s=0, rdata_s holds its last value.
- **Both ports:** both ports may read the same address in the same cycle, and both return identical data, including the forwarded value.
- **Back-to-back reads:** with re held high, one new result is produced per cycle and rvalid stays high.
- **No conflicts:** the write port and the read ports are independent, so no stall and no arbitration exist.

## Timing
- Read latency is 1 cycle. Request at edge N gives data and valid from edge N until edge N+1.
- Write latency is 0 cycles toward reads at the same edge (forwarding). The entry itself is updated at edge N.
- Reset is asserted asynchronously. Deassertion is expected to be synchronous to clk. The first capture occurs on the first rising edge with reset high.
- Reset asserted mid-read:
  - rvalid drops to 0 and rdata clears to 0 immediately;
  - the pending result is lost;
  - no write completes on an edge where reset is low.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold reset low for 3 cycles with re_s=re_t=1, then release. Expect rdata_s=rdata_t=0 and rvalid low during reset, then all 32 addresses read 0x00000000.
- **Write then read:** write 0xDEADBEEF to r5. Next cycle, read r5 on S and T. One cycle later expect rdata_s=rdata_t=0xDEADBEEF and rvalid_s=rvalid_t=1 for exactly 1 cycle.
- **Forwarding:** in the same cycle, write 0x12345678 to r9 and read r9 on S. Expect rdata_s=0x12345678 after that edge, not the old value. Read r9 again next cycle and still expect 0x12345678.
- **Register 0:** write 0xFFFFFFFF to r0, then read r0 on both ports, including in the same cycle as the write. Expect 0x00000000 every time.
- **Streaming:** hold re_s high for 4 cycles with raddr_s = 1, 2, 3, 4, where r1..r4 hold 0x11, 0x22, 0x33, 0x44. Expect those values on consecutive cycles with rvalid_s continuously high. Drop re_s and expect rvalid_s low next cycle with rdata_s held at 0x44.
- **Reset mid-operation:** fill r1..r31 with their index values. Pulse reset low asynchronously between edges during an active read. Expect rdata and rvalid to go to 0 at once and r1..r31 to read 0 afterwards.

Source files
------------

// File: rtl/regbank_2r1w.sv
// 32 x 32-bit register bank: one write port and two registered read ports (S, T).
// Register 0 reads as zero; a same-edge write is forwarded to either read port.
module regbank_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_s,
  input  logic [ADDR_W-1:0] raddr_s,
  output logic [DATA_W-1:0] rdata_s,
  output logic              rvalid_s,
  input  logic              re_t,
  input  logic [ADDR_W-1:0] raddr_t,
  output logic [DATA_W-1:0] rdata_t,
  output logic              rvalid_t
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata_s;
  logic [DATA_W-1:0] r_rdata_t;
  logic              r_rvalid_s;
  logic              r_rvalid_t;
  logic [DATA_W-1:0] w_next_s;
  logic [DATA_W-1:0] w_next_t;
  logic              w_wr_en;

  assign w_wr_en = we && (waddr != '0);

  // Forwarding lets a read see the write landing on the same edge.
  always_comb begin
    w_next_s = r_mem[raddr_s];
    if (raddr_s == '0)
      w_next_s = '0;
    else if (w_wr_en && (waddr == raddr_s))
      w_next_s = wdata;
  end

  always_comb begin
    w_next_t = r_mem[raddr_t];
    if (raddr_t == '0)
      w_next_t = '0;
    else if (w_wr_en && (waddr == raddr_t))
      w_next_t = wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata_s  <= '0;
      r_rvalid_s <= 1'b0;
    end else begin
      r_rvalid_s <= re_s;
      if (re_s)
        r_rdata_s <= w_next_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata_t  <= '0;
      r_rvalid_t <= 1'b0;
    end else begin
      r_rvalid_t <= re_t;
      if (re_t)
        r_rdata_t <= w_next_t;
    end
  end

  assign rdata_s  = r_rdata_s;
  assign rvalid_s = r_rvalid_s;
  assign rdata_t  = r_rdata_t;
  assign rvalid_t = r_rvalid_t;

endmodule

// File: tb/tb_regbank_2r1w.sv
// Self-checking bench for regbank_2r1w: a behavioural model compared every falling
// edge, plus directed vectors with hand-computed literal expectations.
module tb_regbank_2r1w;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re_s = 1'b0;
  logic [4:0]  raddr_s = '0;
  logic [31:0] rdata_s;
  logic        rvalid_s;
  logic        re_t = 1'b0;
  logic [4:0]  raddr_t = '0;
  logic [31:0] rdata_t;
  logic        rvalid_t;

  int checks = 0;
  int failures = 0;

  regbank_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re_s(re_s), .raddr_s(raddr_s), .rdata_s(rdata_s), .rvalid_s(rvalid_s),
    .re_t(re_t), .raddr_t(raddr_t), .rdata_t(rdata_t), .rvalid_t(rvalid_t)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents plus what each port must show.
  logic [31:0] m_regs [32];
  logic [31:0] m_rs, m_rt;
  logic        m_vs, m_vt;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && waddr != 0 && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_rs = 32'h0; m_rt = 32'h0; m_vs = 1'b0; m_vt = 1'b0;
  endtask

  initial model_clear();

  always @(negedge reset) model_clear();

  always @(posedge clk) begin
    if (!reset) begin
      model_clear();
    end else begin
      if (re_s) m_rs = model_read(raddr_s);
      if (re_t) m_rt = model_read(raddr_t);
      m_vs = re_s;
      m_vt = re_t;
      if (we && waddr != 0) m_regs[waddr] = wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model rdata_s", rdata_s, m_rs);
    check("model rvalid_s", {31'h0, rvalid_s}, {31'h0, m_vs});
    check("model rdata_t", rdata_t, m_rt);
    check("model rvalid_t", {31'h0, rvalid_t}, {31'h0, m_vt});
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; re_s = 0; re_t = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle();
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles with reads requested.
    reset = 0; re_s = 1; re_t = 1; raddr_s = 5'd3; raddr_t = 5'd4;
    repeat (3) begin
      tick();
      check("reset rdata_s", rdata_s, 32'h0);
      check("reset rvalid_s", {31'h0, rvalid_s}, 32'h0);
      check("reset rdata_t", rdata_t, 32'h0);
      check("reset rvalid_t", {31'h0, rvalid_t}, 32'h0);
    end
    idle();
    reset = 1;
    for (int i = 0; i < 32; i++) begin
      re_s = 1; raddr_s = 5'(i); re_t = 1; raddr_t = 5'(31 - i);
      tick();
      check("post-reset read s", rdata_s, 32'h0);
      check("post-reset read t", rdata_t, 32'h0);
    end
    idle(); tick();

    // Write then read on both ports; valid is a single-cycle pulse.
    wr(5'd5, 32'hDEADBEEF);
    re_s = 1; raddr_s = 5'd5; re_t = 1; raddr_t = 5'd5;
    tick();
    idle();
    check("wr-rd rdata_s", rdata_s, 32'hDEADBEEF);
    check("wr-rd rdata_t", rdata_t, 32'hDEADBEEF);
    check("wr-rd rvalid_s", {31'h0, rvalid_s}, 32'h1);
    check("wr-rd rvalid_t", {31'h0, rvalid_t}, 32'h1);
    tick();
    check("wr-rd rvalid_s drop", {31'h0, rvalid_s}, 32'h0);
    check("wr-rd rdata_s held", rdata_s, 32'hDEADBEEF);

    // Forwarding on S and on T (T from a different register).
    wr(5'd9, 32'hAAAA0009);
    wr(5'd10, 32'hBBBB000A);
    we = 1; waddr = 5'd9; wdata = 32'h12345678;
    re_s = 1; raddr_s = 5'd9; re_t = 1; raddr_t = 5'd10;
    tick();
    check("fwd rdata_s", rdata_s, 32'h12345678);
    check("fwd rdata_t other", rdata_t, 32'hBBBB000A);
    we = 1; waddr = 5'd10; wdata = 32'hCAFEF00D;
    re_s = 1; raddr_s = 5'd9; re_t = 1; raddr_t = 5'd10;
    tick();
    check("fwd reread s", rdata_s, 32'h12345678);
    check("fwd rdata_t", rdata_t, 32'hCAFEF00D);
    // Both ports on the same forwarded address.
    we = 1; waddr = 5'd12; wdata = 32'h0BADCAFE;
    re_s = 1; raddr_s = 5'd12; re_t = 1; raddr_t = 5'd12;
    tick();
    idle();
    check("fwd same s", rdata_s, 32'h0BADCAFE);
    check("fwd same t", rdata_t, 32'h0BADCAFE);

    // Register 0 stays zero, even when written in the same cycle as the read.
    we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    re_s = 1; raddr_s = 5'd0; re_t = 1; raddr_t = 5'd0;
    tick();
    check("r0 same-cycle s", rdata_s, 32'h0);
    check("r0 same-cycle t", rdata_t, 32'h0);
    we = 0;
    tick();
    idle();
    check("r0 later s", rdata_s, 32'h0);
    check("r0 later t", rdata_t, 32'h0);

    // Streaming reads with re_s held high.
    wr(5'd1, 32'h11); wr(5'd2, 32'h22); wr(5'd3, 32'h33); wr(5'd4, 32'h44);
    for (int i = 1; i <= 4; i++) begin
      re_s = 1; raddr_s = 5'(i);
      tick();
      check("stream rdata_s", rdata_s, 32'h11 * i);
      check("stream rvalid_s", {31'h0, rvalid_s}, 32'h1);
    end
    idle(); raddr_s = 5'd7;
    tick();
    check("stream drop rvalid_s", {31'h0, rvalid_s}, 32'h0);
    check("stream hold rdata_s", rdata_s, 32'h44);

    // Fill r1..r31 with their index, verify, then reset mid-read.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    for (int i = 1; i < 32; i++) begin
      re_s = 1; raddr_s = 5'(i); re_t = 1; raddr_t = 5'(32 - i);
      tick();
      check("fill s", rdata_s, 32'(i));
      check("fill t", rdata_t, 32'(32 - i));
    end
    re_s = 1; raddr_s = 5'd7; re_t = 1; raddr_t = 5'd8;
    tick();
    check("pre-reset rdata_s", rdata_s, 32'd7);
    #2;
    reset = 0;
    #1;
    check("async rdata_s", rdata_s, 32'h0);
    check("async rvalid_s", {31'h0, rvalid_s}, 32'h0);
    check("async rdata_t", rdata_t, 32'h0);
    check("async rvalid_t", {31'h0, rvalid_t}, 32'h0);
    // A write attempted while reset is low must not land.
    idle(); we = 1; waddr = 5'd3; wdata = 32'hAA;
    tick();
    we = 0;
    reset = 1;
    for (int i = 0; i < 32; i++) begin
      re_s = 1; raddr_s = 5'(i); re_t = 1; raddr_t = 5'(i);
      tick();
      check("after reset s", rdata_s, 32'h0);
      check("after reset t", rdata_t, 32'h0);
    end
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
